// File: rtl/instruction_executor.sv
// Pixel instruction executor: decodes cursor/colour/draw opcodes and streams
// framebuffer writes with a running address counter and back-pressure.
module instruction_executor #(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instruction,
    input  logic        i_ready,
    input  logic        i_fb_busy,
    output logic        o_fb_we,
    output logic [14:0] o_fb_addr,
    output logic [7:0]  o_fb_data,
    output logic        o_busy,
    output logic [7:0]  o_cursor_x,
    output logic [6:0]  o_cursor_y,
    output logic        o_bad_opcode
);

    // state  | meaning
    // IDLE   | waiting for a fresh, unconsumed instruction
    // DECODE | latched instruction is being executed
    // WRITE  | issuing framebuffer writes until count reaches zero
    typedef enum logic [1:0] {IDLE, DECODE, WRITE} state_t;

    localparam logic [7:0]  X_MAX     = 8'(FB_WIDTH - 1);
    localparam logic [6:0]  Y_MAX     = 7'(FB_HEIGHT - 1);
    localparam logic [14:0] ADDR_LAST = 15'(FB_WIDTH * FB_HEIGHT - 1);
    localparam logic [15:0] PIX_COUNT = 16'(FB_WIDTH * FB_HEIGHT);

    state_t      state_q,    state_d;
    logic [31:0] instr_q,    instr_d;
    logic        consumed_q, consumed_d;
    logic [7:0]  cursor_x_q, cursor_x_d;
    logic [6:0]  cursor_y_q, cursor_y_d;
    logic [14:0] addr_q,     addr_d;
    logic [7:0]  colour_q,   colour_d;
    logic [7:0]  wdata_q,    wdata_d;
    logic [15:0] count_q,    count_d;
    logic        bad_q,      bad_d;

    logic [7:0] op, arg_b, arg_y, arg_x;
    assign op    = instr_q[7:0];
    assign arg_b = instr_q[15:8];
    assign arg_y = instr_q[23:16];
    assign arg_x = instr_q[31:24];

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        consumed_d = consumed_q;
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        addr_d     = addr_q;
        colour_d   = colour_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        bad_d      = bad_q;

        if (!i_ready) consumed_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_ready && !consumed_q) begin
                    instr_d    = i_instruction;
                    consumed_d = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                state_d = IDLE;
                case (op)
                    8'h00: ;
                    8'h01: begin
                        if (arg_x > X_MAX || arg_y > {1'b0, Y_MAX}) begin
                            bad_d = 1'b1;
                        end else begin
                            cursor_x_d = arg_x;
                            cursor_y_d = arg_y[6:0];
                            // Only place a multiply is needed; writes use the running counter.
                            addr_d     = 15'(arg_y[6:0]) * 15'(FB_WIDTH) + 15'(arg_x);
                        end
                    end
                    8'h02: colour_d = arg_b;
                    8'h03: begin
                        count_d = 16'd1;
                        wdata_d = colour_q;
                        state_d = WRITE;
                    end
                    8'h04: begin
                        count_d = {8'd0, arg_b} + 16'd1;
                        wdata_d = colour_q;
                        state_d = WRITE;
                    end
                    8'h05: begin
                        count_d    = PIX_COUNT;
                        wdata_d    = arg_b;
                        cursor_x_d = 8'd0;
                        cursor_y_d = 7'd0;
                        addr_d     = 15'd0;
                        state_d    = WRITE;
                    end
                    default: bad_d = 1'b1;
                endcase
            end
            WRITE: begin
                if (!i_fb_busy) begin
                    if (cursor_x_q == X_MAX) begin
                        cursor_x_d = 8'd0;
                        cursor_y_d = (cursor_y_q == Y_MAX) ? 7'd0 : cursor_y_q + 7'd1;
                    end else begin
                        cursor_x_d = cursor_x_q + 8'd1;
                    end
                    addr_d  = (addr_q == ADDR_LAST) ? 15'd0 : addr_q + 15'd1;
                    count_d = count_q - 16'd1;
                    if (count_q == 16'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            instr_q    <= 32'd0;
            consumed_q <= 1'b0;
            cursor_x_q <= 8'd0;
            cursor_y_q <= 7'd0;
            addr_q     <= 15'd0;
            colour_q   <= 8'd0;
            wdata_q    <= 8'd0;
            count_q    <= 16'd0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            consumed_q <= consumed_d;
            cursor_x_q <= cursor_x_d;
            cursor_y_q <= cursor_y_d;
            addr_q     <= addr_d;
            colour_q   <= colour_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            bad_q      <= bad_d;
        end
    end

    assign o_fb_we      = (state_q == WRITE);
    assign o_fb_addr    = addr_q;
    assign o_fb_data    = wdata_q;
    assign o_busy       = (state_q != IDLE);
    assign o_cursor_x   = cursor_x_q;
    assign o_cursor_y   = cursor_y_q;
    assign o_bad_opcode = bad_q;

endmodule

// File: tb/tb_instruction_executor.sv
// Directed bench for instruction_executor; expected framebuffer writes are
// queued as instructions are issued and checked as the DUT commits them.
module tb_instruction_executor;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] i_instruction = 32'd0;
    logic        i_ready = 1'b0;
    logic        i_fb_busy = 1'b0;
    logic        o_fb_we;
    logic [14:0] o_fb_addr;
    logic [7:0]  o_fb_data;
    logic        o_busy;
    logic [7:0]  o_cursor_x;
    logic [6:0]  o_cursor_y;
    logic        o_bad_opcode;

    instruction_executor #(.FB_WIDTH(160), .FB_HEIGHT(120)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_instruction(i_instruction),
        .i_ready(i_ready), .i_fb_busy(i_fb_busy), .o_fb_we(o_fb_we),
        .o_fb_addr(o_fb_addr), .o_fb_data(o_fb_data), .o_busy(o_busy),
        .o_cursor_x(o_cursor_x), .o_cursor_y(o_cursor_y),
        .o_bad_opcode(o_bad_opcode)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  wr_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] b,
                                       input logic [7:0] y, input logic [7:0] x);
        return {x, y, b, op};
    endfunction

    // Inputs change only #1 after a rising edge, so at the falling edge
    // o_fb_we && !i_fb_busy predicts acceptance at the next rising edge.
    always @(negedge i_clk) begin
        if (!i_reset && o_fb_we && !i_fb_busy) begin
            wr_t e;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(o_fb_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(o_fb_addr), 32'(e.addr));
                check("wr_data", 32'(o_fb_data), 32'(e.data));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge i_clk);
            if (!o_busy) break;
        end
        check("idle_timeout", 32'(o_busy), 32'd0);
    endtask

    task automatic send(input logic [31:0] ins);
        @(posedge i_clk); #1;
        i_instruction = ins;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        wait_idle();
    endtask

    task automatic check_cursor(input string tag, input logic [7:0] x, input logic [6:0] y);
        check({tag, "_x"}, 32'(o_cursor_x), 32'(x));
        check({tag, "_y"}, 32'(o_cursor_y), 32'(y));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},   32'(o_fb_we), 32'd0);
        check({tag, "_addr"}, 32'(o_fb_addr), 32'd0);
        check({tag, "_data"}, 32'(o_fb_data), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_bad"},  32'(o_bad_opcode), 32'd0);
        check_cursor(tag, 8'd0, 7'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        check_reset_outputs("reset");

        // Colour, cursor, single pixel with latency check
        send(mk(8'h02, 8'h2A, 8'd0, 8'd0));
        send(mk(8'h01, 8'd0, 8'd3, 8'd5));
        check_cursor("set_cursor", 8'd5, 7'd3);
        exp_q.push_back('{addr: 15'd485, data: 8'h2A});
        @(posedge i_clk); #1;
        i_instruction = mk(8'h03, 8'd0, 8'd0, 8'd0);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        @(negedge i_clk);
        check("lat_decode_we", 32'(o_fb_we), 32'd0);
        @(negedge i_clk);
        check("lat_write_we", 32'(o_fb_we), 32'd1);
        wait_idle();
        check_cursor("put_pixel", 8'd6, 7'd3);

        // Span across the end of the framebuffer
        send(mk(8'h01, 8'd0, 8'd119, 8'd158));
        send(mk(8'h02, 8'h11, 8'd0, 8'd0));
        exp_q.push_back('{addr: 15'd19198, data: 8'h11});
        exp_q.push_back('{addr: 15'd19199, data: 8'h11});
        exp_q.push_back('{addr: 15'd0,     data: 8'h11});
        exp_q.push_back('{addr: 15'd1,     data: 8'h11});
        send(mk(8'h04, 8'd3, 8'd0, 8'd0));
        check_cursor("fill_wrap", 8'd2, 7'd0);
        check("fill_pending", 32'(exp_q.size()), 32'd0);

        // Three stalled cycles; colour 0x11 persists
        exp_q.push_back('{addr: 15'd2, data: 8'h11});
        @(posedge i_clk); #1;
        i_fb_busy = 1'b1;
        i_instruction = mk(8'h03, 8'd0, 8'd0, 8'd0);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        @(posedge i_clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("stall_we", 32'(o_fb_we), 32'd1);
            check("stall_addr", 32'(o_fb_addr), 32'd2);
            check("stall_data", 32'(o_fb_data), 32'h11);
            @(posedge i_clk);
        end
        #1 i_fb_busy = 1'b0;
        wait_idle();
        check("stall_we_after", 32'(o_fb_we), 32'd0);
        check_cursor("stall", 8'd3, 7'd0);
        check("stall_pending", 32'(exp_q.size()), 32'd0);

        // Ready held high executes once; re-raise executes again
        exp_q.push_back('{addr: 15'd3, data: 8'h11});
        @(posedge i_clk); #1;
        i_instruction = mk(8'h03, 8'd0, 8'd0, 8'd0);
        i_ready = 1'b1;
        repeat (10) @(posedge i_clk);
        #1 i_ready = 1'b0;
        wait_idle();
        check_cursor("held_ready", 8'd4, 7'd0);
        check("held_pending", 32'(exp_q.size()), 32'd0);
        exp_q.push_back('{addr: 15'd4, data: 8'h11});
        send(mk(8'h03, 8'd0, 8'd0, 8'd0));
        check_cursor("reraise", 8'd5, 7'd0);
        check("reraise_pending", 32'(exp_q.size()), 32'd0);

        // Bad opcode and out-of-range cursor
        check("bad_before", 32'(o_bad_opcode), 32'd0);
        send(mk(8'h7F, 8'd0, 8'd0, 8'd0));
        check("bad_opcode", 32'(o_bad_opcode), 32'd1);
        send(mk(8'h01, 8'd0, 8'd0, 8'd200));
        check("bad_x_sticky", 32'(o_bad_opcode), 32'd1);
        check_cursor("bad_x", 8'd5, 7'd0);
        send(mk(8'h01, 8'd0, 8'd120, 8'd7));
        check_cursor("bad_y", 8'd5, 7'd0);

        // CLEAR interrupted by reset after 100 accepted writes
        for (int i = 0; i < 100; i++)
            exp_q.push_back('{addr: 15'(i), data: 8'h00});
        base = wr_cnt;
        @(posedge i_clk); #1;
        i_instruction = mk(8'h05, 8'h00, 8'd0, 8'd0);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge i_clk);
            if (wr_cnt >= base + 100) break;
        end
        check("clear_count", 32'(wr_cnt - base), 32'd100);
        #1 i_reset = 1'b1;
        i_instruction = mk(8'h03, 8'd0, 8'd0, 8'd0);
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check_reset_outputs("abort");
        check("abort_pending", 32'(exp_q.size()), 32'd0);

        // Ready high through reset release runs once, with reset colour
        exp_q.push_back('{addr: 15'd0, data: 8'h00});
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        repeat (6) @(posedge i_clk);
        #1 i_ready = 1'b0;
        wait_idle();
        check_cursor("post_reset", 8'd1, 7'd0);
        check("post_reset_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_executor.md
INSTRUCTION_EXECUTOR -- requirements
Module: instruction_executor

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 160, framebuffer pixels per row.
REQ-002 SHALL have parameter FB_HEIGHT, default 120, framebuffer rows.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_instruction  input  32  assembled word from the instruction buffer: [7:0] opcode, [15:8] arg B, [23:16] arg Y, [31:24] arg X.
REQ-006 SHALL have port i_ready  input  1  level; high while i_instruction is valid and complete.
REQ-007 SHALL have port i_fb_busy  input  1  framebuffer stall; write not accepted this cycle.
REQ-008 SHALL have port o_fb_we  output  1  framebuffer write request.
REQ-009 SHALL have port o_fb_addr  output  15  linear pixel address, y*FB_WIDTH+x.
REQ-010 SHALL have port o_fb_data  output  8  pixel colour.
REQ-011 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port o_cursor_x  output  8 and o_cursor_y  output  7  current cursor.
REQ-013 SHALL have port o_bad_opcode  output  1  sticky error flag.

Function
REQ-014 SHALL implement states IDLE, DECODE, WRITE; encoding free.
REQ-015 SHALL accept an instruction in IDLE when i_ready=1 and internal consumed flag=0: latch i_instruction, set consumed, go DECODE next cycle.
REQ-016 SHALL clear consumed whenever i_ready=0; an i_ready held high SHALL execute exactly once; i_ready arriving while busy SHALL be accepted on return to IDLE if still high and unconsumed.
REQ-017 SHALL in DECODE execute by opcode: 0x00 NOP -> IDLE; 0x01 SET_CURSOR x=X, y=Y[6:0] -> IDLE; 0x02 SET_COLOR colour=B -> IDLE; 0x03 PUT_PIXEL count=1 -> WRITE; 0x04 FILL_SPAN count=B+1 (1..256) -> WRITE; 0x05 CLEAR colour=B, cursor=(0,0), count=FB_WIDTH*FB_HEIGHT -> WRITE; other -> set o_bad_opcode, IDLE.
REQ-018 SHALL on SET_CURSOR with X>=FB_WIDTH or Y>=FB_HEIGHT leave cursor unchanged and set o_bad_opcode.
REQ-019 SHALL in WRITE hold o_fb_we=1, o_fb_addr=cursor address, o_fb_data=colour; stable until accepted.
REQ-020 SHALL treat a write accepted at a rising edge with o_fb_we=1 and i_fb_busy=0; at most one write per cycle; back-to-back acceptance with no bubble.
REQ-021 SHALL on each accepted write advance cursor: x+1; at x=FB_WIDTH-1 wrap x=0, y+1; at (FB_WIDTH-1, FB_HEIGHT-1) wrap to (0,0); address increments with same wrap (last->0).
REQ-022 SHALL keep address as a running counter updated with the cursor, no multiplier in the write path.
REQ-023 SHALL decrement count on each accepted write and return to IDLE after the write that brings count to 0; o_fb_we SHALL drop that next cycle.
REQ-024 SHALL leave colour unchanged by CLEAR (CLEAR uses B only for its fill); SET_COLOR colour persists across instructions.
REQ-025 SHALL give PUT_PIXEL latency: accept edge N, DECODE at N+1, o_fb_we high from N+2 while no stall.
REQ-026 SHALL keep o_bad_opcode set until reset; it SHALL not block execution.

Reset
REQ-027 SHALL on i_reset=1 at a rising edge set state IDLE, o_fb_we=0, o_fb_addr=0, o_fb_data=0, o_busy=0, cursor (0,0), colour 0x00, count 0, consumed 0, o_bad_opcode=0.
REQ-028 SHALL abort any WRITE/DECODE on reset mid-operation with no further write request the cycle after reset.
REQ-029 SHALL, if i_ready is high when reset deasserts, execute that instruction once.

Verification
REQ-030 SET_COLOR 0x2A, SET_CURSOR X=5 Y=3, PUT_PIXEL -> one write addr 485, data 0x2A; cursor (6,3).
REQ-031 Cursor (158,119), FILL_SPAN B=3, colour 0x11 -> writes addr 19198,19199,0,1; cursor ends (2,0).
REQ-032 PUT_PIXEL with i_fb_busy high 3 cycles -> o_fb_we/addr/data held 3 cycles, one write accepted, then IDLE.
REQ-033 i_ready held high 10 cycles with PUT_PIXEL -> exactly one write; drop and re-raise -> second write at next address.
REQ-034 Opcode 0x7F, then SET_CURSOR X=200 -> o_bad_opcode=1, cursor unchanged; reset clears it.
REQ-035 CLEAR B=0x00, reset asserted after 100 accepted writes -> o_fb_we=0 next cycle, all outputs at reset values.
